echo_delay: RTL

Feedback echo stage between the ADSR envelope output and the codec/display sample register. It consumes one signed 16-bit sample per `in_ready` pulse and produces the echoed mix with a one-cycle `out_ready` pulse. The mix is `out = sat16(in + (delayed >>> DECAY_SHIFT))`, where `delayed` is the output produced 2^ADDR_WIDTH samples earlier, held in a circular on-chip buffer.

---
 rtl/synth_pkg.sv | 25 ++
 rtl/echo_delay_if.sv | 25 ++
 rtl/echo_ram.sv | 28 ++
 rtl/echo_delay.sv | 154 +++++++++++++++
 4 files changed

// File: rtl/synth_pkg.sv
// Shared audio-path definitions: sample width, saturation helper and the
// echo stage state encoding.
package synth_pkg;

    localparam int SAMPLE_W = 16;

    typedef enum logic [2:0] {
        ST_CLEAR,
        ST_IDLE,
        ST_READ,
        ST_MIX,
        ST_WRITE
    } echo_state_e;

    // Clamp a 17-bit signed sum to the 16-bit signed range.
    function automatic logic signed [SAMPLE_W-1:0] sat16(input logic signed [SAMPLE_W:0] s);
        logic signed [SAMPLE_W-1:0] r;
        r = s[SAMPLE_W-1:0];
        if (s[SAMPLE_W] != s[SAMPLE_W-1]) begin
            r = s[SAMPLE_W] ? 16'sh8000 : 16'sh7fff;
        end
        return r;
    endfunction

endpackage

// File: rtl/echo_delay_if.sv
// Sample stream between the envelope stage and the echo stage.
// Handshake: in_ready is a one-cycle strobe qualifying sample_in/enable in the
// same cycle; out_ready is a one-cycle strobe marking a new sample_out.
interface echo_delay_if;
    import synth_pkg::*;

    logic                       enable;
    logic signed [SAMPLE_W-1:0] sample_in;
    logic                       in_ready;
    logic signed [SAMPLE_W-1:0] sample_out;
    logic                       out_ready;
    logic                       busy;
    logic                       overrun;

    modport master (
        output enable, sample_in, in_ready,
        input  sample_out, out_ready, busy, overrun
    );

    modport slave (
        input  enable, sample_in, in_ready,
        output sample_out, out_ready, busy, overrun
    );

endinterface

// File: rtl/echo_ram.sv
// Single-port delay-line memory, synchronous read-first, block-RAM inferable.
module echo_ram #(
    parameter int ADDR_WIDTH = 12,
    parameter int DATA_W     = 16
) (
    input  logic                  clk,
    input  logic                  we_i,
    input  logic                  re_i,
    input  logic [ADDR_WIDTH-1:0] addr_i,
    input  logic [DATA_W-1:0]     wdata_i,
    output logic [DATA_W-1:0]     rdata_o
);

    logic [DATA_W-1:0] mem_q [2**ADDR_WIDTH];
    logic [DATA_W-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[addr_i] <= wdata_i;
        end
        if (re_i) begin
            rdata_q <= mem_q[addr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/echo_delay.sv
// Feedback echo: out = sat16(in + (out delayed 2^ADDR_WIDTH samples >>> DECAY_SHIFT)),
// with a zeroing sweep of the delay line after every reset.
module echo_delay
    import synth_pkg::*;
#(
    parameter int ADDR_WIDTH  = 12,
    parameter int DECAY_SHIFT = 1
) (
    input  logic        clk,
    input  logic        reset,
    echo_delay_if.slave bus,
    output echo_state_e dbg_state_o
);

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = '1;

    echo_state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0]      ptr_q, ptr_d;
    logic [ADDR_WIDTH-1:0]      clr_addr_q, clr_addr_d;
    logic signed [SAMPLE_W-1:0] in_q, in_d;
    logic                       en_q, en_d;
    logic signed [SAMPLE_W-1:0] sample_out_q, sample_out_d;
    logic                       out_ready_q, out_ready_d;
    logic                       overrun_q, overrun_d;
    logic                       pt1_v_q, pt1_v_d, pt2_v_q, pt2_v_d;
    logic signed [SAMPLE_W-1:0] pt1_data_q, pt1_data_d, pt2_data_q, pt2_data_d;

    logic                       ram_we, ram_re;
    logic [ADDR_WIDTH-1:0]      ram_addr;
    logic [SAMPLE_W-1:0]        ram_wdata, ram_rdata;
    logic signed [SAMPLE_W-1:0] delayed, decayed, mix;
    logic signed [SAMPLE_W:0]   sum;

    echo_ram #(.ADDR_WIDTH(ADDR_WIDTH), .DATA_W(SAMPLE_W)) u_ram (
        .clk    (clk),
        .we_i   (ram_we && !reset),
        .re_i   (ram_re),
        .addr_i (ram_addr),
        .wdata_i(ram_wdata),
        .rdata_o(ram_rdata)
    );

    always_comb begin
        delayed = $signed(ram_rdata);
        decayed = delayed >>> DECAY_SHIFT;
        sum     = {in_q[SAMPLE_W-1], in_q} + {decayed[SAMPLE_W-1], decayed};
        mix     = en_q ? sat16(sum) : in_q;
    end

    always_comb begin
        state_d      = state_q;
        ptr_d        = ptr_q;
        clr_addr_d   = clr_addr_q;
        in_d         = in_q;
        en_d         = en_q;
        sample_out_d = sample_out_q;
        out_ready_d  = 1'b0;
        overrun_d    = overrun_q;
        pt1_v_d      = 1'b0;
        pt1_data_d   = pt1_data_q;
        pt2_v_d      = pt1_v_q;
        pt2_data_d   = pt1_data_q;
        ram_we       = 1'b0;
        ram_re       = 1'b0;
        ram_addr     = ptr_q;
        ram_wdata    = sample_out_q;

        // Dry samples accepted during the clear sweep ride a 2-stage shadow pipe.
        if (pt2_v_q) begin
            sample_out_d = pt2_data_q;
            out_ready_d  = 1'b1;
        end

        case (state_q)
            ST_CLEAR: begin
                ram_we     = 1'b1;
                ram_addr   = clr_addr_q;
                ram_wdata  = '0;
                clr_addr_d = clr_addr_q + ADDR_WIDTH'(1);
                if (clr_addr_q == LAST_ADDR) state_d = ST_IDLE;
                if (bus.in_ready) begin
                    if (!pt1_v_q && !pt2_v_q) begin
                        pt1_v_d    = 1'b1;
                        pt1_data_d = bus.sample_in;
                    end else begin
                        overrun_d = 1'b1;
                    end
                end
            end
            ST_IDLE: begin
                if (bus.in_ready) begin
                    in_d    = bus.sample_in;
                    en_d    = bus.enable;
                    ram_re  = 1'b1;
                    state_d = ST_READ;
                end
            end
            ST_READ: begin
                state_d = ST_MIX;
                if (bus.in_ready) overrun_d = 1'b1;
            end
            ST_MIX: begin
                sample_out_d = mix;
                out_ready_d  = 1'b1;
                state_d      = ST_WRITE;
                if (bus.in_ready) overrun_d = 1'b1;
            end
            ST_WRITE: begin
                ram_we  = 1'b1;
                ptr_d   = ptr_q + ADDR_WIDTH'(1);
                state_d = ST_IDLE;
                if (bus.in_ready) overrun_d = 1'b1;
            end
            default: state_d = ST_CLEAR;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_CLEAR;
            ptr_q        <= '0;
            clr_addr_q   <= '0;
            in_q         <= '0;
            en_q         <= 1'b0;
            sample_out_q <= '0;
            out_ready_q  <= 1'b0;
            overrun_q    <= 1'b0;
            pt1_v_q      <= 1'b0;
            pt2_v_q      <= 1'b0;
            pt1_data_q   <= '0;
            pt2_data_q   <= '0;
        end else begin
            state_q      <= state_d;
            ptr_q        <= ptr_d;
            clr_addr_q   <= clr_addr_d;
            in_q         <= in_d;
            en_q         <= en_d;
            sample_out_q <= sample_out_d;
            out_ready_q  <= out_ready_d;
            overrun_q    <= overrun_d;
            pt1_v_q      <= pt1_v_d;
            pt2_v_q      <= pt2_v_d;
            pt1_data_q   <= pt1_data_d;
            pt2_data_q   <= pt2_data_d;
        end
    end

    assign bus.sample_out = sample_out_q;
    assign bus.out_ready  = out_ready_q;
    assign bus.busy       = (state_q == ST_CLEAR);
    assign bus.overrun    = overrun_q;
    assign dbg_state_o    = state_q;

endmodule
